// File: rtl/pcap_dma_sched.sv
`default_nettype none
// =============================================================================
// pcap_dma_sched : schedules sample-FIFO words into host DDR buffers as bursts
// Optional macro PCAP_DMA_TIMEOUT_EN adds an idle timer for partial bursts.
// Revision: 1.0
// =============================================================================
module pcap_dma_sched #(
  parameter int BURST_LEN = 16,
  parameter int BUF_WORDS = 1024,
  parameter int TBL_DEPTH = 32,
  parameter int FIFO_AW   = 11
) (
  input  logic               clk_i,
  input  logic               resetn_i,
  input  logic               arm_i,
  input  logic               disarm_i,
  input  logic               addr_wr_i,
  input  logic [31:0]        addr_data_i,
  input  logic [FIFO_AW-1:0] fifo_count_i,
  output logic               dma_req_o,
  output logic [31:0]        dma_addr_o,
  output logic [7:0]         dma_len_o,
  input  logic               dma_ack_i,
  input  logic               dma_err_i,
  output logic               armed_o,
  output logic               irq_o,
  output logic [7:0]         irq_status_o,
  output logic [15:0]        smpl_count_o,
  output logic [5:0]         tbl_count_o
);

  localparam int          PW      = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1;
  localparam logic [15:0] C_BURST = 16'(BURST_LEN);
  localparam logic [15:0] C_BUF   = 16'(BUF_WORDS);
  localparam logic [5:0]  C_DEPTH = 6'(TBL_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT     = 3'd1,
    S_REQ      = 3'd2,
    S_FLUSH    = 3'd3,
    S_BUF_DONE = 3'd4,
    S_COMPLETE = 3'd5
  } state_t;

  logic [31:0]   tbl_mem [TBL_DEPTH];
  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [5:0]    tbl_cnt_q, tbl_cnt_d;
  logic [31:0]   cur_addr_q, cur_addr_d;
  logic [15:0]   smpl_q, smpl_d;
  logic          armed_q, armed_d;
  logic          flush_q, flush_d;
  logic          und_q, und_d;
  logic          err_q, err_d;
  logic          ovr_q, ovr_d;
  logic          dma_req_q, dma_req_d;
  logic [31:0]   dma_addr_q, dma_addr_d;
  logic [7:0]    dma_len_q, dma_len_d;
  logic          irq_q, irq_d;
  logic [7:0]    irq_status_q, irq_status_d;
  logic [15:0]   smpl_count_q, smpl_count_d;

  logic          tbl_full, tbl_empty, push, pop, ovr_set;
  logic          issue, tmo_fire;
  logic [15:0]   issue_len, fifo_w, rem_w, blen_w, resid_w, smpl_sum;

  assign fifo_w    = 16'(fifo_count_i);
  assign rem_w     = C_BUF - smpl_q;
  assign blen_w    = (rem_w < C_BURST) ? rem_w : C_BURST;
  assign resid_w   = (fifo_w < blen_w) ? fifo_w : blen_w;
  assign smpl_sum  = smpl_q + 16'(dma_len_q);
  assign tbl_full  = (tbl_cnt_q == C_DEPTH);
  assign tbl_empty = (tbl_cnt_q == 6'd0);
  assign push      = addr_wr_i && !tbl_full;
  assign ovr_set   = addr_wr_i && tbl_full;

`ifdef PCAP_DMA_TIMEOUT_EN
  logic [23:0] idle_cnt_q, idle_cnt_d;
  logic        part_fill;

  always_comb begin
    part_fill  = (fifo_w != 16'd0) && (fifo_w < C_BURST);
    idle_cnt_d = ((state_q == S_WAIT) && part_fill) ? idle_cnt_q + 24'd1 : 24'd0;
    tmo_fire   = (state_q == S_WAIT) && part_fill && (idle_cnt_q == 24'hFF_FFFF);
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) idle_cnt_q <= 24'd0;
    else           idle_cnt_q <= idle_cnt_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    smpl_d       = smpl_q;
    armed_d      = armed_q;
    flush_d      = flush_q || (armed_q && disarm_i);
    und_d        = und_q;
    err_d        = err_q;
    dma_req_d    = dma_req_q;
    dma_addr_d   = dma_addr_q;
    dma_len_d    = dma_len_q;
    irq_d        = 1'b0;
    irq_status_d = irq_status_q;
    smpl_count_d = smpl_count_q;
    pop          = 1'b0;
    issue        = 1'b0;
    issue_len    = resid_w;

    case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          armed_d = 1'b1;
          smpl_d  = 16'd0;
          und_d   = 1'b0;
          err_d   = 1'b0;
          flush_d = disarm_i;
          if (tbl_empty) begin
            und_d   = 1'b1;
            state_d = S_COMPLETE;
          end else begin
            pop        = 1'b1;
            cur_addr_d = tbl_mem[rd_ptr_q];
            state_d    = disarm_i ? S_FLUSH : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dma_err_i) begin
          err_d   = 1'b1;
          state_d = S_COMPLETE;
        end else if (flush_q || disarm_i) begin
          state_d = S_FLUSH;
        end else if (fifo_w >= C_BURST) begin
          issue     = 1'b1;
          issue_len = blen_w;
        end else if (tmo_fire) begin
          issue = 1'b1;
        end
      end
      S_REQ: begin
        // The burst is never withdrawn on disarm; only an AXI error abandons it.
        if (dma_err_i) begin
          err_d     = 1'b1;
          dma_req_d = 1'b0;
          state_d   = S_COMPLETE;
        end else if (dma_ack_i) begin
          dma_req_d = 1'b0;
          smpl_d    = smpl_sum;
          if (smpl_sum == C_BUF)            state_d = S_BUF_DONE;
          else if (flush_q || disarm_i)     state_d = S_FLUSH;
          else                              state_d = S_WAIT;
        end
      end
      S_FLUSH: begin
        if (dma_err_i) begin
          err_d   = 1'b1;
          state_d = S_COMPLETE;
        end else if (resid_w != 16'd0) begin
          issue = 1'b1;
        end else begin
          state_d = S_COMPLETE;
        end
      end
      S_BUF_DONE: begin
        irq_d        = 1'b1;
        irq_status_d = {2'b00, 1'b0, ovr_q, err_q, und_q, 1'b0, 1'b1};
        smpl_count_d = C_BUF;
        smpl_d       = 16'd0;
        if (dma_err_i) begin
          err_d   = 1'b1;
          state_d = S_COMPLETE;
        end else if (tbl_empty) begin
          und_d   = 1'b1;
          state_d = S_COMPLETE;
        end else begin
          pop        = 1'b1;
          cur_addr_d = tbl_mem[rd_ptr_q];
          state_d    = (flush_q || disarm_i) ? S_FLUSH : S_WAIT;
        end
      end
      S_COMPLETE: begin
        // Bit 1 marks an orderly end; underrun/error endings report only their own bit.
        // Bit 5 (external-timeout disarm) has no source inside this block.
        irq_d        = 1'b1;
        irq_status_d = {2'b00, 1'b0, ovr_q, err_q, und_q, !(err_q || und_q), 1'b0};
        smpl_count_d = smpl_q;
        armed_d      = 1'b0;
        flush_d      = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      state_d    = S_REQ;
      dma_req_d  = 1'b1;
      dma_addr_d = cur_addr_q + {14'd0, smpl_q, 2'b00};
      dma_len_d  = issue_len[7:0];
    end

    ovr_d = ovr_set || (ovr_q && !irq_d);
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    tbl_cnt_d = tbl_cnt_q;
    case ({push, pop})
      2'b10:   tbl_cnt_d = tbl_cnt_q + 6'd1;
      2'b01:   tbl_cnt_d = tbl_cnt_q - 6'd1;
      default: tbl_cnt_d = tbl_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) tbl_mem[wr_ptr_q] <= addr_data_i;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tbl_cnt_q    <= 6'd0;
      cur_addr_q   <= 32'd0;
      smpl_q       <= 16'd0;
      armed_q      <= 1'b0;
      flush_q      <= 1'b0;
      und_q        <= 1'b0;
      err_q        <= 1'b0;
      ovr_q        <= 1'b0;
      dma_req_q    <= 1'b0;
      dma_addr_q   <= 32'd0;
      dma_len_q    <= 8'd0;
      irq_q        <= 1'b0;
      irq_status_q <= 8'd0;
      smpl_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tbl_cnt_q    <= tbl_cnt_d;
      cur_addr_q   <= cur_addr_d;
      smpl_q       <= smpl_d;
      armed_q      <= armed_d;
      flush_q      <= flush_d;
      und_q        <= und_d;
      err_q        <= err_d;
      ovr_q        <= ovr_d;
      dma_req_q    <= dma_req_d;
      dma_addr_q   <= dma_addr_d;
      dma_len_q    <= dma_len_d;
      irq_q        <= irq_d;
      irq_status_q <= irq_status_d;
      smpl_count_q <= smpl_count_d;
    end
  end

  assign dma_req_o    = dma_req_q;
  assign dma_addr_o   = dma_addr_q;
  assign dma_len_o    = dma_len_q;
  assign armed_o      = armed_q;
  assign irq_o        = irq_q;
  assign irq_status_o = irq_status_q;
  assign smpl_count_o = smpl_count_q;
  assign tbl_count_o  = tbl_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pcap_dma_sched.sv
`default_nettype none
// tb_pcap_dma_sched: directed stimulus, expected bursts/IRQs queued and
// compared by an independent monitor; a responder acks or errors bursts.
module tb_pcap_dma_sched;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        arm = 1'b0, disarm = 1'b0, addr_wr = 1'b0;
  logic [31:0] addr_data = 32'd0;
  logic [10:0] fifo = 11'd0;
  logic        ack = 1'b0, err = 1'b0;
  logic        dma_req_o, armed_o, irq_o;
  logic [31:0] dma_addr_o;
  logic [7:0]  dma_len_o, irq_status_o;
  logic [15:0] smpl_count_o;
  logic [5:0]  tbl_count_o;

  pcap_dma_sched dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .arm_i        (arm),
    .disarm_i     (disarm),
    .addr_wr_i    (addr_wr),
    .addr_data_i  (addr_data),
    .fifo_count_i (fifo),
    .dma_req_o    (dma_req_o),
    .dma_addr_o   (dma_addr_o),
    .dma_len_o    (dma_len_o),
    .dma_ack_i    (ack),
    .dma_err_i    (err),
    .armed_o      (armed_o),
    .irq_o        (irq_o),
    .irq_status_o (irq_status_o),
    .smpl_count_o (smpl_count_o),
    .tbl_count_o  (tbl_count_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } burst_t;
  typedef struct { logic [7:0] st; logic [15:0] cnt; } irq_t;

  burst_t exp_b[$];
  irq_t   exp_i[$];
  int     n_chk = 0, n_pass = 0;
  int     resp_cnt = 0, irq_seen = 0, err_at = 0;
  bit     hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, want);
  endtask

  task automatic exp_burst(input logic [31:0] a, input logic [7:0] l);
    burst_t b;
    b.addr = a; b.len = l;
    exp_b.push_back(b);
  endtask

  task automatic exp_irq(input logic [7:0] s, input logic [15:0] c);
    irq_t q;
    q.st = s; q.cnt = c;
    exp_i.push_back(q);
  endtask

  task automatic pulse(input bit a, input bit d, input bit w, input logic [31:0] data);
    @(negedge clk);
    arm = a; disarm = d; addr_wr = w; addr_data = data;
    @(negedge clk);
    arm = 1'b0; disarm = 1'b0; addr_wr = 1'b0;
  endtask

  task automatic wait_irq(input int target);
    int cyc = 0;
    while (irq_seen < target && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("irq_arrival", 32'(irq_seen >= target), 32'd1);
  endtask

  task automatic wait_bursts(input int target);
    int cyc = 0;
    while (resp_cnt < target && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("burst_arrival", 32'(resp_cnt >= target), 32'd1);
  endtask

  // DMA responder: acks each new request one cycle later, or errors the chosen one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ack || err) begin
        ack = 1'b0;
        err = 1'b0;
      end else if (dma_req_o && !hold) begin
        resp_cnt++;
        if (resp_cnt == err_at) err = 1'b1;
        else begin
          ack  = 1'b1;
          fifo = fifo - 11'(dma_len_o);
        end
      end
    end
  end

  // Monitor: compares every new burst and IRQ against the scoreboard queues.
  initial begin
    logic prev_req, prev_err;
    prev_req = 1'b0;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_err) check("req_drop_after_err", 32'(dma_req_o), 32'd0);
      if (dma_req_o && !prev_req) begin
        check("burst_expected", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) begin
          burst_t b;
          b = exp_b.pop_front();
          check("burst_addr", dma_addr_o, b.addr);
          check("burst_len", 32'(dma_len_o), 32'(b.len));
        end
      end
      if (irq_o) begin
        irq_seen++;
        check("irq_expected", 32'(exp_i.size() != 0), 32'd1);
        if (exp_i.size() != 0) begin
          irq_t q;
          q = exp_i.pop_front();
          check("irq_status", 32'(irq_status_o), 32'(q.st));
          check("irq_count", 32'(smpl_count_o), 32'(q.cnt));
        end
      end
      prev_req = dma_req_o && resetn;
      prev_err = err;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_req", 32'(dma_req_o), 32'd0);
    check("rst_armed", 32'(armed_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_status", 32'(irq_status_o), 32'd0);
    check("rst_tbl", 32'(tbl_count_o), 32'd0);

    // Full buffer then disarm: BUF_DONE IRQ, then COMPLETE IRQ with count 0.
    pulse(0, 0, 1, 32'h1000_0000);
    pulse(0, 0, 1, 32'h1000_1000);
    check("tbl_two", 32'(tbl_count_o), 32'd2);
    for (int i = 0; i < 64; i++) exp_burst(32'h1000_0000 + 32'(i * 64), 8'd16);
    exp_irq(8'h01, 16'd1024);
    exp_irq(8'h02, 16'd0);
    fifo = 11'd1024;
    pulse(1, 0, 0, 32'd0);
    wait_bursts(64);
    wait_irq(1);
    pulse(0, 1, 0, 32'd0);
    wait_irq(2);
    check("armed_after_t1", 32'(armed_o), 32'd0);

    // 37 words: two full bursts, disarm flushes the residual 5.
    pulse(0, 0, 1, 32'h1000_0000);
    exp_burst(32'h1000_0000, 8'd16);
    exp_burst(32'h1000_0040, 8'd16);
    exp_burst(32'h1000_0080, 8'd5);
    exp_irq(8'h02, 16'd37);
    fifo = 11'd37;
    pulse(1, 0, 0, 32'd0);
    wait_bursts(66);
    repeat (4) @(negedge clk);
    pulse(0, 1, 0, 32'd0);
    wait_irq(3);
    check("fifo_after_t2", 32'(fifo), 32'd0);

    // Arm with empty table: underrun IRQ, armed drops quickly.
    exp_irq(8'h04, 16'd0);
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    check("armed_set", 32'(armed_o), 32'd1);
    repeat (2) @(negedge clk);
    check("armed_clr_empty", 32'(armed_o), 32'd0);
    wait_irq(4);

    // One address, 1040 words, no disarm: underrun after the buffer fills.
    pulse(0, 0, 1, 32'h2000_0000);
    for (int i = 0; i < 64; i++) exp_burst(32'h2000_0000 + 32'(i * 64), 8'd16);
    exp_irq(8'h01, 16'd1024);
    exp_irq(8'h04, 16'd0);
    fifo = 11'd1040;
    pulse(1, 0, 0, 32'd0);
    wait_irq(6);
    repeat (10) @(negedge clk);
    check("no_65th_burst", 32'(fifo), 32'd16);
    check("armed_after_t4", 32'(armed_o), 32'd0);
    fifo = 11'd0;

    // AXI error on the third burst.
    pulse(0, 0, 1, 32'h3000_0000);
    err_at = resp_cnt + 3;
    exp_burst(32'h3000_0000, 8'd16);
    exp_burst(32'h3000_0040, 8'd16);
    exp_burst(32'h3000_0080, 8'd16);
    exp_irq(8'h08, 16'd32);
    fifo = 11'd64;
    pulse(1, 0, 0, 32'd0);
    wait_irq(7);
    check("fifo_after_err", 32'(fifo), 32'd32);
    fifo = 11'd0;
    err_at = 0;

    // Table overrun: 33 writes keep 32 entries, overrun reported once.
    for (int i = 0; i < 33; i++) pulse(0, 0, 1, 32'h4000_0000 + 32'(i * 32'h1000));
    check("tbl_full", 32'(tbl_count_o), 32'd32);
    exp_irq(8'h12, 16'd0);
    pulse(1, 1, 0, 32'd0);
    wait_irq(8);
    check("tbl_after_pop", 32'(tbl_count_o), 32'd31);

    // Arm+disarm together with a simultaneous push: flush 5 words, count unchanged.
    exp_burst(32'h4000_1000, 8'd5);
    exp_irq(8'h02, 16'd5);
    fifo = 11'd5;
    pulse(1, 1, 1, 32'h5000_0000);
    check("tbl_push_pop", 32'(tbl_count_o), 32'd31);
    wait_irq(9);

    // Reset while a request is outstanding.
    hold = 1'b1;
    exp_burst(32'h4000_2000, 8'd16);
    fifo = 11'd16;
    pulse(1, 0, 0, 32'd0);
    begin
      int cyc = 0;
      while (!dma_req_o && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("req_before_reset", 32'(dma_req_o), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("req_async_drop", 32'(dma_req_o), 32'd0);
    check("armed_async_drop", 32'(armed_o), 32'd0);
    check("tbl_async_clr", 32'(tbl_count_o), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    hold = 1'b0;
    fifo = 11'd0;

    repeat (10) @(negedge clk);
    check("burst_queue_drained", 32'(exp_b.size()), 32'd0);
    check("irq_queue_drained", 32'(exp_i.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
